// File: rtl/window_builder.sv
// window_builder: turns a raster pixel stream into 3x3 neighbourhood windows
// using two line buffers and a three-column shift register.
module window_builder #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [7:0]                iPixel,
  input  logic                      iValid,
  input  logic                      iSof,
  output logic [71:0]               oGrid,
  output logic                      oValid,
  output logic [$clog2(WIDTH)-1:0]  oCol,
  output logic [$clog2(HEIGHT)-1:0] oRow
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  logic [XW-1:0] x, ex, nx;
  logic [YW-1:0] y, ey, ny;
  logic [7:0] lb1 [WIDTH];
  logic [7:0] lb2 [WIDTH];
  logic [23:0] c0, c1, c2;
  logic [71:0] grid;
  logic x_end, emit;
  // iSof forces the accepted pixel to (0,0) regardless of counter state
  always_comb begin
    ex = iSof ? '0 : x;
    ey = iSof ? '0 : y;
    x_end = ex == XW'(WIDTH - 1);
    nx = x_end ? '0 : ex + 1'b1;
    ny = x_end ? (ey == YW'(HEIGHT - 1) ? '0 : ey + 1'b1) : ey;
    c0 = {lb2[ex], lb1[ex], iPixel};
    emit = iValid && ex >= XW'(2) && ey >= YW'(2);
    grid = {c2[7:0], c1[7:0], c0[7:0], c2[15:8], c1[15:8], c0[15:8], c2[23:16], c1[23:16], c0[23:16]};
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      x <= '0;
      y <= '0;
      c1 <= '0;
      c2 <= '0;
      oValid <= 1'b0;
      oGrid <= '0;
      oCol <= '0;
      oRow <= '0;
    end else begin
      oValid <= emit;
      if (iValid) begin
        x <= nx;
        y <= ny;
        c1 <= c0;
        c2 <= c1;
      end
      if (emit) begin
        oGrid <= grid;
        oCol <= ex - 1'b1;
        oRow <= ey - 1'b1;
      end
    end
  end
  // line buffer contents survive reset; the x/y>=2 gate hides stale data
  always_ff @(posedge clk) begin
    if (iValid) begin
      lb2[ex] <= lb1[ex];
      lb1[ex] <= iPixel;
    end
  end
endmodule
